// File: rtl/nios2_exec.sv
// nios2_exec: multi-cycle execute engine for an integer subset of Nios II.
// Single issue; ldw and mul hold off the stream until they retire.
module nios2_exec #(
  parameter int DATA_W     = 32,
  parameter int DMEM_DEPTH = 64,
  parameter int MUL_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   instr,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  output logic                          retire_valid,
  output logic [31:0]                   retire_pc,
  output logic                          br_valid,
  output logic                          br_taken,
  output logic [31:0]                   br_target,
  output logic [31:0]                   pc,
  output logic                          illegal,
  input  logic                          ld_we,
  input  logic [$clog2(DMEM_DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]             ld_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [DATA_W-1:0]             dbg_rdata
);
  localparam int AW     = $clog2(DMEM_DEPTH);
  localparam int STEP_W = (DATA_W + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam int CNT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [DATA_W-1:0] CHUNK_MASK = {DATA_W{1'b1}} >> (DATA_W - STEP_W);

  localparam logic [5:0] OP_ADDI  = 6'h04;
  localparam logic [5:0] OP_LDW   = 6'h17;
  localparam logic [5:0] OP_STW   = 6'h15;
  localparam logic [5:0] OP_BR    = 6'h06;
  localparam logic [5:0] OP_BLT   = 6'h16;
  localparam logic [5:0] OP_BGE   = 6'h0E;
  localparam logic [5:0] OP_BEQ   = 6'h26;
  localparam logic [5:0] OP_BNE   = 6'h1E;
  localparam logic [5:0] OP_RTYPE = 6'h3A;
  localparam logic [5:0] OPX_ADD  = 6'h31;
  localparam logic [5:0] OPX_SUB  = 6'h39;
  localparam logic [5:0] OPX_MUL  = 6'h27;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4:0]          dst_q, dst_d;
  logic [31:0]         pc_q, next_pc;
  logic                retire_valid_q, br_valid_q, br_taken_q, illegal_q;
  logic [31:0]         retire_pc_q, br_target_q;
  logic [DATA_W-1:0]   rf_q [32];
  logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]   mem_rdata_q;
  logic [DATA_W-1:0]   acc_q, mul_a_q, mul_b_q;

  logic [4:0]          ra, rb, rc;
  logic [5:0]          op, opx;
  logic [DATA_W-1:0]   imm_x, va, vb, ea;
  logic [31:0]         imm32;
  logic [AW-1:0]       mem_idx;
  logic                accept;
  logic [DATA_W-1:0]   a_cur, b_cur, acc_cur, acc_step;

  logic                wr_en, st_en, fin, is_br, take, bad;
  logic [4:0]          wr_addr;
  logic [DATA_W-1:0]   wr_data;

  assign ra      = instr[31:27];
  assign rb      = instr[26:22];
  assign rc      = instr[21:17];
  assign opx     = instr[16:11];
  assign op      = instr[5:0];
  assign imm_x   = DATA_W'($signed(instr[21:6]));
  assign imm32   = 32'($signed(instr[21:6]));
  assign va      = rf_q[ra];
  assign vb      = rf_q[rb];
  assign ea      = va + imm_x;
  assign mem_idx = AW'(ea >> 2);

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  // One multiplier step consumes STEP_W bits of rB; the acceptance cycle is step 0.
  assign a_cur    = (state_q == S_MUL) ? mul_a_q : va;
  assign b_cur    = (state_q == S_MUL) ? mul_b_q : vb;
  assign acc_cur  = (state_q == S_MUL) ? acc_q : '0;
  assign acc_step = acc_cur + a_cur * (b_cur & CHUNK_MASK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    st_en   = 1'b0;
    fin     = 1'b0;
    is_br   = 1'b0;
    take    = 1'b0;
    bad     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          fin = 1'b1;
          case (op)
            OP_ADDI: begin wr_en = 1'b1; wr_addr = rb; wr_data = ea; end
            OP_LDW:  begin fin = 1'b0; dst_d = rb; state_d = S_LOAD; end
            OP_STW:  st_en = 1'b1;
            OP_BR:   begin is_br = 1'b1; take = 1'b1; end
            OP_BLT:  begin is_br = 1'b1; take = $signed(va) <  $signed(vb); end
            OP_BGE:  begin is_br = 1'b1; take = $signed(va) >= $signed(vb); end
            OP_BEQ:  begin is_br = 1'b1; take = (va == vb); end
            OP_BNE:  begin is_br = 1'b1; take = (va != vb); end
            OP_RTYPE: begin
              case (opx)
                OPX_ADD: begin wr_en = 1'b1; wr_addr = rc; wr_data = va + vb; end
                OPX_SUB: begin wr_en = 1'b1; wr_addr = rc; wr_data = va - vb; end
                OPX_MUL: begin
                  if (MUL_CYCLES == 1) begin
                    wr_en = 1'b1; wr_addr = rc; wr_data = acc_step;
                  end else begin
                    fin     = 1'b0;
                    dst_d   = rc;
                    cnt_d   = CNT_W'(MUL_CYCLES - 1);
                    state_d = S_MUL;
                  end
                end
                default: bad = 1'b1;
              endcase
            end
            default: bad = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = mem_rdata_q;
        fin     = 1'b1;
        state_d = S_IDLE;
      end
      S_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          wr_en   = 1'b1;
          wr_addr = dst_q;
          wr_data = acc_step;
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign next_pc = (is_br && take) ? pc_q + 32'd4 + imm32 : pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dst_q          <= '0;
      pc_q           <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      br_valid_q     <= 1'b0;
      br_taken_q     <= 1'b0;
      br_target_q    <= '0;
      illegal_q      <= 1'b0;
      acc_q          <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dst_q          <= dst_d;
      retire_valid_q <= fin;
      br_valid_q     <= is_br;
      br_taken_q     <= is_br && take;
      acc_q          <= acc_step;
      mul_a_q        <= a_cur << STEP_W;
      mul_b_q        <= b_cur >> STEP_W;
      if (fin) begin
        retire_pc_q <= pc_q;
        pc_q        <= next_pc;
      end
      if (is_br) br_target_q <= next_pc;
      if (bad) illegal_q <= 1'b1;
    end
  end

  // r0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  // Core store is written last so it wins a same-word collision with the loader.
  always_ff @(posedge clk) begin
    if (ld_we) dmem[ld_addr] <= ld_wdata;
    if (st_en) dmem[mem_idx] <= vb;
    mem_rdata_q <= dmem[mem_idx];
  end

  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;
  assign br_valid     = br_valid_q;
  assign br_taken     = br_taken_q;
  assign br_target    = br_target_q;
  assign pc           = pc_q;
  assign illegal      = illegal_q;
  assign dbg_rdata    = (dbg_raddr == 5'd0) ? '0 : rf_q[dbg_raddr];
endmodule

// File: tb/tb_nios2_exec.sv
// Bench for nios2_exec: an ISA-level model predicts each retirement into a
// scoreboard queue; a monitor pops and compares on every retire pulse.
`timescale 1ns/1ps
module tb_nios2_exec;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        br_valid, br_taken;
  logic [31:0] br_target, pc;
  logic        illegal;
  logic        ld_we;
  logic [5:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  nios2_exec #(.DATA_W(32), .DMEM_DEPTH(64), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target), .pc(pc),
    .illegal(illegal), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        br_hist[$];
  logic        last_taken;
  logic [31:0] last_target;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          retire_cnt = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic        m_illegal;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ienc(input logic [5:0] op, input int a, input int b, input int imm);
    return {5'(a), 5'(b), 16'(imm), op};
  endfunction

  function automatic logic [31:0] renc(input logic [5:0] opx, input int a, input int b, input int c);
    return {5'(a), 5'(b), 5'(c), opx, 5'd0, 6'h3A};
  endfunction

  task automatic mset(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) m_rf[d] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = '0;
    m_illegal = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_exec(input logic [31:0] w);
    logic [5:0]  op, opx, idx;
    logic [4:0]  a, b, c;
    logic [31:0] imm, va, vb, nxt;
    logic        tk, isb;
    exp_t        e;
    op = w[5:0]; opx = w[16:11];
    a = w[31:27]; b = w[26:22]; c = w[21:17];
    imm = {{16{w[21]}}, w[21:6]};
    va = m_rf[a]; vb = m_rf[b];
    idx = 6'((va + imm) >> 2);
    tk = 1'b0; isb = 1'b0;
    case (op)
      6'h04: mset(b, va + imm);
      6'h17: mset(b, m_mem[idx]);
      6'h15: m_mem[idx] = vb;
      6'h06: begin isb = 1'b1; tk = 1'b1; end
      6'h16: begin isb = 1'b1; tk = $signed(va) <  $signed(vb); end
      6'h0E: begin isb = 1'b1; tk = $signed(va) >= $signed(vb); end
      6'h26: begin isb = 1'b1; tk = (va == vb); end
      6'h1E: begin isb = 1'b1; tk = (va != vb); end
      6'h3A: begin
        case (opx)
          6'h31: mset(c, va + vb);
          6'h39: mset(c, va - vb);
          6'h27: mset(c, va * vb);
          default: m_illegal = 1'b1;
        endcase
      end
      default: m_illegal = 1'b1;
    endcase
    nxt = (isb && tk) ? m_pc + 32'd4 + imm : m_pc + 32'd4;
    e.pc = m_pc; e.br = isb; e.taken = tk; e.tgt = nxt;
    sb_q.push_back(e);
    m_pc = nxt;
  endtask

  // Presents w until accepted; waits = cycles instr_ready was low first.
  task automatic issue(input logic [31:0] w, output int waits);
    waits = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (!instr_ready) begin
      check("issue_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    model_exec(w);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic issue1(input logic [31:0] w);
    int unused_waits;
    issue(w, unused_waits);
  endtask

  task automatic load_word(input int addr, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = 6'(addr); ld_wdata = d;
    @(posedge clk);
    @(negedge clk);
    ld_we = 1'b0;
    m_mem[addr] = d;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    check("pc", pc, m_pc);
    check("illegal", 32'(illegal), 32'(m_illegal));
    #1;
  endtask

  task automatic check_reg(input string tag, input int r, input logic [31:0] exp);
    dbg_raddr = 5'(r);
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && retire_valid) begin
      retire_cnt++;
      if (sb_q.size() == 0) begin
        check("retire_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("retire_pc", retire_pc, mon_e.pc);
        check("br_valid", 32'(br_valid), 32'(mon_e.br));
        if (mon_e.br) begin
          check("br_taken", 32'(br_taken), 32'(mon_e.taken));
          check("br_target", br_target, mon_e.tgt);
        end
      end
      if (br_valid) begin
        br_hist.push_back(br_taken);
        last_taken = br_taken;
        last_target = br_target;
      end
    end else if (!rst && br_valid) begin
      check("br_without_retire", 32'd1, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rc0, w_ld, w_mul, w_after, steps;
    logic [31:0] p, base;
    logic [31:0] prog [8];

    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; dbg_raddr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_pc", pc, 32'd0);
    check("rst_retire_valid", 32'(retire_valid), 32'd0);
    check("rst_retire_pc", retire_pc, 32'd0);
    check("rst_br_taken", 32'(br_taken), 32'd0);
    check("rst_br_target", br_target, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // addi then dependent add
    @(negedge clk);
    rc0 = retire_cnt;
    issue1(32'h00800144);
    issue1(renc(6'h31, 2, 2, 5));
    drain();
    check_reg("add_r5", 5, 32'd10);
    check("t1_retires", 32'(retire_cnt - rc0), 32'd2);
    check("t1_pc", pc, 32'd8);

    // loader, ldw then mul back-to-back
    @(negedge clk);
    load_word(0, 32'd3); load_word(1, 32'd4); load_word(2, 32'd5);
    issue(ienc(6'h17, 0, 6, 0), w_ld);
    issue(renc(6'h27, 6, 6, 8), w_mul);
    issue(renc(6'h31, 8, 8, 9), w_after);
    check("ldw_stall", 32'(w_mul), 32'd1);
    check("mul_stall", 32'(w_after), 32'd3);
    drain();
    check_reg("ldw_r6", 6, 32'd3);
    check_reg("mul_r8", 8, 32'd9);
    check_reg("fwd_r9", 9, 32'd18);

    // dot product {1,2,3}.{4,5,6}
    @(negedge clk);
    for (int i = 0; i < 6; i++) load_word(i, 32'(i + 1));
    issue1(ienc(6'h04, 0, 1, 0));
    issue1(ienc(6'h04, 0, 2, 12));
    issue1(ienc(6'h04, 0, 5, 0));
    issue1(ienc(6'h04, 0, 7, 3));
    prog[0] = ienc(6'h17, 1, 3, 0);
    prog[1] = ienc(6'h17, 2, 4, 0);
    prog[2] = renc(6'h27, 3, 4, 6);
    prog[3] = renc(6'h31, 5, 6, 5);
    prog[4] = ienc(6'h04, 1, 1, 4);
    prog[5] = ienc(6'h04, 2, 2, 4);
    prog[6] = ienc(6'h04, 7, 7, -1);
    prog[7] = ienc(6'h16, 0, 7, -32);
    br_hist.delete();
    base = m_pc;
    steps = 0;
    while (m_pc >= base && m_pc < base + 32 && steps < 40) begin
      issue1(prog[(m_pc - base) >> 2]);
      steps++;
    end
    issue1(ienc(6'h15, 0, 5, 0));
    issue1(ienc(6'h17, 0, 12, 0));
    drain();
    check_reg("dot_r5", 5, 32'd32);
    check_reg("dot_mem0", 12, 32'd32);
    check("br_count", 32'(br_hist.size()), 32'd3);
    if (br_hist.size() == 3) begin
      check("br_hist0", 32'(br_hist[0]), 32'd1);
      check("br_hist1", 32'(br_hist[1]), 32'd1);
      check("br_hist2", 32'(br_hist[2]), 32'd0);
    end

    // loader/stw same-word collision, address wrap and low bits
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 6'd7; ld_wdata = 32'hDEAD_BEEF;
    m_mem[7] = 32'hDEAD_BEEF;
    issue1(ienc(6'h15, 0, 5, 28));
    ld_we = 1'b0;
    issue1(ienc(6'h17, 0, 13, 28));
    issue1(ienc(6'h17, 0, 14, 260));
    issue1(ienc(6'h17, 0, 15, 7));
    drain();
    check_reg("stw_wins", 13, 32'd32);
    check_reg("addr_wrap", 14, 32'd2);
    check_reg("addr_low_bits", 15, 32'd2);

    // signed blt both ways
    @(negedge clk);
    issue1(ienc(6'h04, 0, 9, -1));
    p = m_pc;
    issue1(ienc(6'h16, 9, 0, 8));
    drain();
    check("blt_neg_taken", 32'(last_taken), 32'd1);
    check("blt_neg_target", last_target, p + 32'd12);
    @(negedge clk);
    p = m_pc;
    issue1(ienc(6'h16, 0, 9, 8));
    drain();
    check("blt_pos_taken", 32'(last_taken), 32'd0);
    check("blt_pos_target", last_target, p + 32'd4);

    // illegal opcode / OPX and r0 write
    @(negedge clk);
    check("illegal_before", 32'(illegal), 32'd0);
    p = m_pc;
    issue1(32'h0000_003F);
    issue1(ienc(6'h04, 0, 0, 7));
    drain();
    check("illegal_set", 32'(illegal), 32'd1);
    check("illegal_pc", pc, p + 32'd8);
    check_reg("r0_zero", 0, 32'd0);
    @(negedge clk);
    issue1(renc(6'h00, 1, 2, 3));
    issue1(ienc(6'h04, 0, 1, 1));
    drain();
    check("illegal_sticky", 32'(illegal), 32'd1);

    // reset during the second MUL cycle
    @(negedge clk);
    issue1(ienc(6'h04, 0, 10, 3));
    drain();
    @(negedge clk);
    check("mul_accept_ready", 32'(instr_ready), 32'd1);
    instr = renc(6'h27, 10, 10, 11);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    rc0 = retire_cnt;
    #1;
    check("abort_ready_low", 32'(instr_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_pc", pc, 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_illegal", 32'(illegal), 32'd0);
    check_reg("abort_r11", 11, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_retire", 32'(retire_cnt - rc0), 32'd0);

    // engine runs normally after the abort
    @(negedge clk);
    issue1(32'h00800144);
    drain();
    check_reg("post_rst_r2", 2, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/nios2_exec.md
# nios2_exec

Parametrised successor to the single-issue Nios II datapath: a multi-cycle execute engine for the integer subset the team's programs use.
- Instructions arrive on a valid/ready stream from a fetch stage or bench.
- The engine owns a 32-entry register file, a word-addressed data memory, an internal PC and an iterative multiplier.
- It reports every retired instruction and every resolved branch back to the fetch side.

## Interface
Parameters:
- DATA_W, 32: datapath and register width; minimum 16.
- DMEM_DEPTH, 64: data memory depth in words; power of two.
- MUL_CYCLES, 4: execute cycles taken by mul; minimum 1.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- instr, in, 32: Nios II instruction word.
- instr_valid, in, 1: instr is presented.
- instr_ready, out, 1: engine accepts instr this cycle.
- retire_valid, out, 1: one-cycle pulse when an instruction completes.
- retire_pc, out, 32: PC of the retiring instruction.
- br_valid, out, 1: one-cycle pulse when a branch resolves.
- br_taken, out, 1: the resolved branch was taken.
- br_target, out, 32: next PC after the branch.
- pc, out, 32: PC of the next instruction to accept.
- illegal, out, 1: sticky flag; an unsupported opcode/OPX was accepted.
- ld_we, in, 1: loader write enable into data memory.
- ld_addr, in, log2(DMEM_DEPTH): loader word address.
- ld_wdata, in, DATA_W: loader write data.
- dbg_raddr, in, 5: register debug read address.
- dbg_rdata, out, DATA_W: combinational read of reg[dbg_raddr]; always 0 for r0.

## Operation
Decode uses standard Nios II fields.
- I-type: A=[31:27], B=[26:22], IMM16=[21:6], OP=[5:0].
- R-type: OP=0x3A, C=[21:17], OPX=[16:11].
- IMM16 is sign-extended to DATA_W.

Supported instructions:
- addi (0x04): rB = rA + imm.
- ldw (0x17): rB = mem[(rA+imm)>>2].
- stw (0x15): mem[(rA+imm)>>2] = rB.
- br (0x06).
- blt (0x16): signed rA < rB.
- bge (0x0E): signed rA >= rB.
- beq (0x26) and bne (0x1E).
- R-type add (OPX 0x31), sub (0x39), mul (0x27): rC = rA op rB.

Arithmetic and addressing rules:
- All arithmetic wraps modulo 2^DATA_W.
- mul keeps the low DATA_W bits.
- Memory index = bits [log2(DMEM_DEPTH)+1:2] of the effective address. Address bits [1:0] are ignored, and upper bits wrap.

Register and PC rules:
- Writes to r0 are discarded.
- The PC advances by 4 per retire.
- A taken branch sets PC = retire_pc + 4 + imm. A not-taken branch sets PC = retire_pc + 4.

Unsupported opcodes:
- An unsupported OP/OPX retires as a no-op.
- It sets illegal, which stays set until rst.

State machine:
- IDLE: instr_ready=1. On instr_valid:
  - ALU/branch/stw/illegal instructions complete in the same cycle, and the engine stays in IDLE.
  - ldw moves to LOAD.
  - mul moves to MUL with counter = MUL_CYCLES-1.
- LOAD: instr_ready=0. Synchronous memory data arrives; rB is written and the instruction retires. Next state is IDLE.
- MUL: instr_ready=0. The counter decrements each cycle. At 0, rC is written and the instruction retires. Next state is IDLE. With MUL_CYCLES=1, mul retires in the acceptance cycle.

Loader port:
- ld_we writes data memory in any cycle.
- If ld_we and a core stw hit the same word in the same cycle, the stw data wins.

## Timing
- Reset values:
  - state IDLE, pc=0, all registers 0, illegal=0.
  - retire_valid, br_valid and br_taken are 0; br_target=0 and retire_pc=0.
  - instr_ready=0 while rst is asserted and 1 in the first cycle after release.
  - Data memory contents are not reset.
- Register/memory writes and retire/branch outputs are registered. They are visible the cycle after completion.
- Latency: 1 cycle for ALU/branch/stw, 2 for ldw, MUL_CYCLES for mul.
- Throughput: one instruction per cycle in IDLE.
- Handshake: an instruction is consumed only when instr_valid && instr_ready. instr may change freely when not accepted.
- Back-to-back dependency: a value written by the previous instruction is forwarded. Reads never return stale data.
- Reset asserted mid-LOAD or mid-MUL aborts the instruction: no register write and no retire_valid.

## Test plan
- Reset, then addi r2,r0,5 (0x00800144) followed by add r5,r2,r2 -> dbg_rdata(r5)=10; retire_valid pulses twice; pc=8.
- Loader writes mem[0..2]={3,4,5}, then ldw r6,0(r0) followed immediately by mul r8,r6,r6 with MUL_CYCLES=4 -> instr_ready is low for 1 cycle, then for 3 cycles; r8=9; forwarding is correct.
- Dot-product loop (ldw, ldw, mul, add, addi, addi, subi, blt) for 3 iterations over {1,2,3}·{4,5,6}, then stw r5 -> mem[0]=32; br_taken=1 twice, then 0.
- blt with rA=-1, rB=0 -> br_taken=1 and br_target=pc+4+imm; with rA=0, rB=-1 -> br_taken=0.
- Opcode 0x3F, then a write to r0 -> illegal=1 and stays set; r0 still reads 0; pc advances by 4 for each.
- rst asserted during the second MUL cycle -> no write to rC, no retire pulse, pc=0 after release, instr_ready=1.
